sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one sram_ctrl command port between two bus masters: port A (CPU via sram_cache) and port B (DMA/video fetch).
- Sits between the masters and sram_ctrl; it does not touch the SRAM pins.
- Round-robin grant with grant parking and a burst limit, so one master cannot starve the other.
- Both sides use the same strobe/wait handshake: a transfer completes at a posedge where strobe=1 and wait=0.

Parameters:
- MAX_BURST, 4: max back-to-back transfers by the granted master while the other master is requesting (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- a_addr  in  17  port A word address
- a_wrdata  in  32  port A write data
- a_bytesel  in  4  port A byte enables
- a_wren  in  1  port A write=1/read=0
- a_strobe  in  1  port A request
- a_wait  out  1  port A stall
- a_rddata  out  32  port A read data
- b_addr, b_wrdata, b_bytesel, b_wren, b_strobe, b_wait, b_rddata: same widths/meaning as port A, for port B
- m_addr  out  17  to sram_ctrl
- m_wrdata  out  32  to sram_ctrl
- m_bytesel  out  4  to sram_ctrl
- m_wren  out  1  to sram_ctrl
- m_strobe  out  1  to sram_ctrl
- m_wait  in  1  from sram_ctrl
- m_rddata  in  32  from sram_ctrl

Behaviour:
- Masters hold strobe and all request fields stable until completion (strobe=1, wait=0 at a posedge).
- States: IDLE, GNT_A, GNT_B (registered); burst_cnt register, 4 bits.
- Reset (asynchronous, active-low):
  - state=IDLE, burst_cnt=0.
  - m_strobe=0 immediately, because it is decoded from state.
  - m_addr/m_wrdata/m_bytesel/m_wren=0; a_wait=b_wait=1.
- IDLE:
  - a_strobe=1 -> GNT_A next cycle.
  - Else b_strobe=1 -> GNT_B next cycle.
  - Simultaneous requests -> GNT_A.
  - No requests -> stay in IDLE. IDLE is reached only from reset.
- GNT_x, mux rules:
  - m_* equal port x's inputs combinationally.
  - m_strobe = x_strobe.
  - x_wait = m_wait.
  - The other port's wait = 1.
  - m_* are zero in IDLE.
- Read data: a_rddata = b_rddata = m_rddata (broadcast); only the granted port's value is meaningful.
- Grant latency: a request to a non-granted port sees wait=1 for at least one cycle (grant registration), then the sram_ctrl latency.
- Completion edge in GNT_x (x_strobe & !m_wait):
  - If the other port's strobe=1 and burst_cnt+1 >= MAX_BURST -> switch to the other grant, burst_cnt=0.
  - Else stay in GNT_x, burst_cnt = burst_cnt+1, saturating at 15.
- Non-completion edges in GNT_x:
  - x_strobe=0 and other strobe=1 -> switch to the other grant, burst_cnt=0.
  - x_strobe=0 and other strobe=0 -> park in GNT_x.
  - x_strobe=1 and m_wait=1 -> hold; no switch is ever taken mid-transfer.
- Simultaneous completion of x and a new request from y with burst_cnt+1 < MAX_BURST: x keeps the grant. If x re-requests, y waits up to MAX_BURST transfers.
- Parked grant: a new request from the parked master proceeds with no arbitration bubble (zero added latency).
- MAX_BURST=1: strict alternation whenever both ports request.

Decomposition:
- Shared include sram_arb_defs.vh: state encodings (IDLE=2'd0, GNT_A=2'd1, GNT_B=2'd2) and burst counter width.
- No sub-module: the request mux and the FSM stay in one module, around 150 lines.
- A later N-port version would split out sram_arb_rr (round-robin grant logic).

Test Plan:
- Reset, then A write 0x55AABEEF @0x00010 with bytesel 1111 -> GNT_A one cycle after strobe; A then reads 0x00010 -> a_rddata=0x55AABEEF; b_wait=1 throughout.
- A and B strobe in the same cycle after reset, A @0x00001, B @0x00002 -> A completes first, then B; m_addr shows 0x00001 then 0x00002.
- MAX_BURST=4; A issues 8 continuous reads while B holds one request -> B completes after exactly 4 A completions; A's remaining 4 follow.
- Park: A completes, idles 3 cycles, re-strobes -> m_strobe rises in the same cycle as a_strobe, with no bubble.
- Reset asserted with m_wait=1 mid-transfer -> m_strobe=0 and a_wait=b_wait=1 immediately; state=IDLE; the next A request is granted normally.
- B write bytesel 0100 data 0x12345678 @0x10000, then B read -> b_rddata[23:16]=0x34, other bytes preserved; a_wait stays 1 while A has no request.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: grant state encoding and burst counter width for sram_arbiter
package sram_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;
    localparam int BURST_W = 4;
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin share of one sram_ctrl command port between two masters
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] a_addr,
    input  logic [31:0] a_wrdata,
    input  logic [3:0]  a_bytesel,
    input  logic        a_wren,
    input  logic        a_strobe,
    output logic        a_wait,
    output logic [31:0] a_rddata,
    input  logic [16:0] b_addr,
    input  logic [31:0] b_wrdata,
    input  logic [3:0]  b_bytesel,
    input  logic        b_wren,
    input  logic        b_strobe,
    output logic        b_wait,
    output logic [31:0] b_rddata,
    output logic [16:0] m_addr,
    output logic [31:0] m_wrdata,
    output logic [3:0]  m_bytesel,
    output logic        m_wren,
    output logic        m_strobe,
    input  logic        m_wait,
    input  logic [31:0] m_rddata
);
    state_t             state;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W:0]   cnt_inc;
    logic               gnt_a, gnt_b, other_req, done, switch_gnt;

    assign gnt_a = state == GNT_A;
    assign gnt_b = state == GNT_B;

    assign m_addr    = gnt_a ? a_addr    : gnt_b ? b_addr    : '0;
    assign m_wrdata  = gnt_a ? a_wrdata  : gnt_b ? b_wrdata  : '0;
    assign m_bytesel = gnt_a ? a_bytesel : gnt_b ? b_bytesel : '0;
    assign m_wren    = gnt_a ? a_wren    : gnt_b ? b_wren    : 1'b0;
    assign m_strobe  = gnt_a ? a_strobe  : gnt_b ? b_strobe  : 1'b0;
    assign a_wait    = gnt_a ? m_wait : 1'b1;
    assign b_wait    = gnt_b ? m_wait : 1'b1;
    assign a_rddata  = m_rddata;
    assign b_rddata  = m_rddata;

    // Switch only between transfers: after a completion that exhausts the burst, or while the holder is idle
    assign other_req  = gnt_a ? b_strobe : a_strobe;
    assign done       = m_strobe & ~m_wait;
    assign cnt_inc    = {1'b0, burst_cnt} + 1'b1;
    assign switch_gnt = other_req & (done ? cnt_inc >= (BURST_W+1)'(MAX_BURST) : ~m_strobe);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else if (state == IDLE)
            state <= a_strobe ? GNT_A : b_strobe ? GNT_B : IDLE;
        else if (switch_gnt) begin
            state     <= gnt_a ? GNT_B : GNT_A;
            burst_cnt <= '0;
        end else if (done)
            burst_cnt <= &burst_cnt ? burst_cnt : burst_cnt + 1'b1;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed vector table plus multi-cycle sequences against a small sram_ctrl model
module tb_sram_arbiter;
    logic        clk = 0, reset = 0;
    logic [16:0] a_addr = 0, b_addr = 0, m_addr;
    logic [31:0] a_wrdata = 0, b_wrdata = 0, m_wrdata, a_rddata, b_rddata, m_rddata;
    logic [3:0]  a_bytesel = 0, b_bytesel = 0, m_bytesel;
    logic        a_wren = 0, b_wren = 0, m_wren, a_strobe = 0, b_strobe = 0, m_strobe;
    logic        a_wait, b_wait, m_wait;
    logic        use_model = 0, tb_wait = 0, busy = 0;
    logic [31:0] tb_rddata = 0;
    logic [31:0] mem [0:131071];
    int          n_vec = 0, n_bad = 0;
    bit          port_log [$];
    logic [16:0] addr_log [$];

    sram_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .a_addr(a_addr), .a_wrdata(a_wrdata), .a_bytesel(a_bytesel), .a_wren(a_wren),
        .a_strobe(a_strobe), .a_wait(a_wait), .a_rddata(a_rddata),
        .b_addr(b_addr), .b_wrdata(b_wrdata), .b_bytesel(b_bytesel), .b_wren(b_wren),
        .b_strobe(b_strobe), .b_wait(b_wait), .b_rddata(b_rddata),
        .m_addr(m_addr), .m_wrdata(m_wrdata), .m_bytesel(m_bytesel), .m_wren(m_wren),
        .m_strobe(m_strobe), .m_wait(m_wait), .m_rddata(m_rddata)
    );

    always #5 clk = ~clk;

    // sram_ctrl model: one wait cycle, then completes with combinational read data
    assign m_wait   = use_model ? ~busy : tb_wait;
    assign m_rddata = use_model ? mem[m_addr] : tb_rddata;
    always @(posedge clk) begin
        busy <= m_strobe & ~busy;
        if (m_strobe && busy && m_wren)
            for (int i = 0; i < 4; i++)
                if (m_bytesel[i]) mem[m_addr][8*i +: 8] <= m_wrdata[8*i +: 8];
    end

    typedef struct packed {
        bit       as, bs, mw;
        bit [1:0] g;
        bit       ms, aw, bw;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        {a_addr, a_wrdata, a_bytesel, a_wren, a_strobe} = {17'h1ABCD, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1};
        b_strobe = 1;
        #1 chk("reset outputs", {m_strobe, a_wait, b_wait, m_wren, m_bytesel, m_addr},
               {1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 17'h0});
        chk("reset m_wrdata", m_wrdata, 32'h0);
        repeat (2) @(negedge clk);
        a_strobe = 0;
        b_strobe = 0;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic xfer(input bit p, input logic [16:0] ad, input logic [31:0] wd, input logic [3:0] be,
                        input bit wr, output logic [31:0] rd, output int cyc, output bit ms0,
                        output bit other_low);
        bit done = 0;
        @(negedge clk);
        if (p) {b_addr, b_wrdata, b_bytesel, b_wren, b_strobe} = {ad, wd, be, wr, 1'b1};
        else   {a_addr, a_wrdata, a_bytesel, a_wren, a_strobe} = {ad, wd, be, wr, 1'b1};
        cyc = 0;
        other_low = 0;
        rd = '0;
        #1 ms0 = m_strobe;
        for (int k = 0; k < 50 && !done; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            cyc++;
            if ((p ? a_wait : b_wait) == 1'b0) other_low = 1;
            if ((p ? b_wait : a_wait) == 1'b0) begin
                rd = p ? b_rddata : a_rddata;
                done = 1;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL xfer timeout: port %0d never completed, required completion", p);
        end
        @(posedge clk);
        #1;
        if (p) b_strobe = 0;
        else   a_strobe = 0;
    endtask

    task automatic run_both(input int na, input int nb);
        int a_left = na, b_left = nb;
        bit cmp, pa;
        port_log.delete();
        addr_log.delete();
        {a_addr, a_wren, a_strobe} = {17'h00001, 1'b0, na > 0};
        {b_addr, b_wren, b_strobe} = {17'h00002, 1'b0, nb > 0};
        for (int k = 0; k < 200 && (a_left > 0 || b_left > 0); k++) begin
            @(negedge clk);
            #1;
            cmp = m_strobe & ~m_wait;
            pa = ~a_wait;
            if (cmp) begin
                port_log.push_back(!pa);
                addr_log.push_back(m_addr);
            end
            @(posedge clk);
            #1;
            if (cmp && pa) begin
                a_left--;
                if (a_left == 0) a_strobe = 0;
            end else if (cmp) begin
                b_left--;
                if (b_left == 0) b_strobe = 0;
            end
        end
        if (a_left > 0 || b_left > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_both timeout: %0d/%0d left, required 0/0", a_left, b_left);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        bit          ms0, olow;
        logic [8:0]  ord;

        tbl = '{
            '{0,0,0, 2'd0, 0,1,1}, '{1,1,0, 2'd0, 0,1,1}, '{1,1,1, 2'd1, 1,1,1},
            '{1,1,0, 2'd1, 1,0,1}, '{1,1,0, 2'd1, 1,0,1}, '{1,1,0, 2'd1, 1,0,1},
            '{1,1,0, 2'd1, 1,0,1}, '{1,1,0, 2'd2, 1,1,0}, '{1,0,0, 2'd2, 0,1,0},
            '{0,0,0, 2'd1, 0,0,1}, '{1,0,0, 2'd1, 1,0,1}, '{0,1,1, 2'd1, 0,1,1},
            '{0,1,1, 2'd2, 1,1,1}, '{1,1,1, 2'd2, 1,1,1}, '{1,1,0, 2'd2, 1,1,0},
            '{1,1,0, 2'd2, 1,1,0}, '{1,1,0, 2'd2, 1,1,0}, '{1,1,0, 2'd2, 1,1,0},
            '{1,1,1, 2'd1, 1,1,1}
        };

        do_reset();
        {a_addr, a_wrdata, a_bytesel, a_wren} = {17'h00AAA, 32'h11111111, 4'h3, 1'b1};
        {b_addr, b_wrdata, b_bytesel, b_wren} = {17'h00BBB, 32'h22222222, 4'hC, 1'b0};
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            {a_strobe, b_strobe, tb_wait} = {tbl[i].as, tbl[i].bs, tbl[i].mw};
            tb_rddata = 32'hC0DE0000 + i;
            #1;
            chk($sformatf("vec%0d ctl", i), {7'd0, m_strobe, a_wait, b_wait, m_wren, m_bytesel, m_addr},
                {7'd0, tbl[i].ms, tbl[i].aw, tbl[i].bw, tbl[i].g == 2'd1,
                 tbl[i].g == 2'd1 ? 4'h3 : tbl[i].g == 2'd2 ? 4'hC : 4'h0,
                 tbl[i].g == 2'd1 ? 17'h00AAA : tbl[i].g == 2'd2 ? 17'h00BBB : 17'h0});
            chk($sformatf("vec%0d wrdata", i), m_wrdata,
                tbl[i].g == 2'd1 ? 32'h11111111 : tbl[i].g == 2'd2 ? 32'h22222222 : 32'h0);
            chk($sformatf("vec%0d a_rddata", i), a_rddata, 32'hC0DE0000 + i);
            chk($sformatf("vec%0d b_rddata", i), b_rddata, 32'hC0DE0000 + i);
        end
        a_strobe = 0;
        b_strobe = 0;

        use_model = 1;
        do_reset();
        xfer(0, 17'h00010, 32'h55AABEEF, 4'hF, 1, rd, cyc, ms0, olow);
        chk("A write cycles", cyc, 3);
        chk("A write b_wait", olow, 0);
        xfer(0, 17'h00010, 32'h0, 4'hF, 0, rd, cyc, ms0, olow);
        chk("A read data", rd, 32'h55AABEEF);
        chk("A read cycles", cyc, 2);
        chk("A read b_wait", olow, 0);
        repeat (3) @(negedge clk);
        xfer(0, 17'h00010, 32'h0, 4'hF, 0, rd, cyc, ms0, olow);
        chk("park no bubble", ms0, 1);
        chk("park cycles", cyc, 2);

        xfer(1, 17'h10000, 32'hAABBCCDD, 4'hF, 1, rd, cyc, ms0, olow);
        chk("B prewrite cycles", cyc, 3);
        chk("B prewrite a_wait", olow, 0);
        xfer(1, 17'h10000, 32'h12345678, 4'b0100, 1, rd, cyc, ms0, olow);
        chk("B bytewrite a_wait", olow, 0);
        xfer(1, 17'h10000, 32'h0, 4'hF, 0, rd, cyc, ms0, olow);
        chk("B byte lane", rd[23:16], 8'h34);
        chk("B read word", rd, 32'hAA34CCDD);
        chk("B read a_wait", olow, 0);

        @(negedge clk);
        {a_addr, a_wren, a_strobe} = {17'h00005, 1'b0, 1'b1};
        @(negedge clk);
        #1 chk("midxfer pre", {m_strobe, m_wait}, 2'b11);
        reset = 0;
        #1 chk("midxfer reset", {m_strobe, a_wait, b_wait, m_addr}, {1'b0, 1'b1, 1'b1, 17'h0});
        @(negedge clk);
        a_strobe = 0;
        @(negedge clk);
        reset = 1;
        xfer(0, 17'h00010, 32'h0, 4'hF, 0, rd, cyc, ms0, olow);
        chk("post reset cycles", cyc, 3);
        chk("post reset data", rd, 32'h55AABEEF);

        do_reset();
        run_both(1, 1);
        chk("simul count", port_log.size(), 2);
        if (port_log.size() == 2) begin
            chk("simul order", {port_log[0], port_log[1]}, 2'b01);
            chk("simul addrs", {addr_log[0], addr_log[1]}, {17'h00001, 17'h00002});
        end

        do_reset();
        run_both(8, 1);
        chk("burst count", port_log.size(), 9);
        ord = '0;
        foreach (port_log[i]) ord = {ord[7:0], port_log[i]};
        chk("burst order", ord, 9'b000010000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1);
    end
endmodule
